// File: rtl/resp_pkg.sv
// Shared constants for the data SRAM responder: MMIO map, default window and CON_STAT layout.
package resp_pkg;

    localparam logic [15:0] MMIO_HI_DEF = 16'hBFAF;

    localparam logic [15:0] OFF_LED       = 16'h0000;
    localparam logic [15:0] OFF_TIMER     = 16'h0004;
    localparam logic [15:0] OFF_TIMER_CMP = 16'h0008;
    localparam logic [15:0] OFF_INT_STAT  = 16'h000C;
    localparam logic [15:0] OFF_CON_TX    = 16'h0010;
    localparam logic [15:0] OFF_CON_STAT  = 16'h0014;

    localparam int CS_FULL_BIT  = 0;
    localparam int CS_EMPTY_BIT = 1;
    localparam int CS_OVF_BIT   = 2;
    localparam int CS_COUNT_LSB = 4;

    function automatic logic [31:0] con_stat_word(input logic       full,
                                                  input logic       empty,
                                                  input logic       ovf,
                                                  input logic [2:0] count);
        logic [31:0] w;
        w = '0;
        w[CS_FULL_BIT]                    = full;
        w[CS_EMPTY_BIT]                   = empty;
        w[CS_OVF_BIT]                     = ovf;
        w[CS_COUNT_LSB+2:CS_COUNT_LSB]    = count;
        return w;
    endfunction

endpackage

// File: rtl/resp_tx_fifo.sv
// 4-deep x 8-bit console TX FIFO; a push into a full FIFO is accepted when a pop happens on the same edge.
module resp_tx_fifo (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic       full,
    output logic       empty,
    output logic [2:0] count,
    output logic [7:0] head
);

    logic [7:0] slot_q [4];
    logic [7:0] slot_d [4];
    logic [1:0] wr_ptr_q, wr_ptr_d;
    logic [1:0] rd_ptr_q, rd_ptr_d;
    logic [2:0] count_q, count_d;
    logic       do_push, do_pop;

    always_comb begin
        do_pop   = pop & (count_q != 3'd0);
        do_push  = push & ((count_q != 3'd4) | do_pop);
        slot_d   = slot_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            slot_d[wr_ptr_q] = push_data;
            wr_ptr_d         = wr_ptr_q + 2'd1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 2'd1;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + 3'd1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            count_q  <= 3'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: head is forced to zero while empty.
    always_ff @(posedge clk) begin
        slot_q <= slot_d;
    end

    assign full  = (count_q == 3'd4);
    assign empty = (count_q == 3'd0);
    assign count = count_q;
    assign head  = empty ? 8'h00 : slot_q[rd_ptr_q];

endmodule

// File: rtl/data_sram_responder.sv
// Data SRAM port responder: byte-writable word memory with 1-cycle read latency,
// plus an MMIO window with LED, free-running timer/compare interrupt and console TX FIFO.
module data_sram_responder
    import resp_pkg::*;
#(
    parameter int          MEM_AW  = 14,
    parameter logic [15:0] MMIO_HI = MMIO_HI_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_we,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic [15:0] led,
    output logic        timer_int,
    output logic        con_valid,
    output logic [7:0]  con_data,
    input  logic        con_ready
);

    logic [31:0]       mem_q [2**MEM_AW];
    logic [31:0]       mem_rdata_q;
    logic [MEM_AW-1:0] mem_idx;

    logic        is_mmio, wr_any;
    logic        mem_wr, mem_rd, mmio_wr, mmio_rd;
    logic [15:0] off;

    logic        src_mem_q, src_mem_d;
    logic [31:0] mmio_rdata_q, mmio_rdata_d;
    logic [15:0] led_q, led_d;
    logic [31:0] timer_q, timer_d;
    logic [31:0] cmp_q, cmp_d;
    logic        pend_q, pend_d;
    logic        ovf_q, ovf_d;

    logic        fifo_push;
    logic        fifo_full, fifo_empty;
    logic [2:0]  fifo_count;
    logic [7:0]  fifo_head;

    assign is_mmio = (data_sram_addr[31:16] == MMIO_HI);
    assign off     = data_sram_addr[15:0];
    assign mem_idx = data_sram_addr[MEM_AW+1:2];
    assign wr_any  = |data_sram_we;

    // The request on a reset cycle is dropped, including memory writes.
    assign mem_wr  = data_sram_en & ~is_mmio &  wr_any & ~rst;
    assign mem_rd  = data_sram_en & ~is_mmio & ~wr_any & ~rst;
    assign mmio_wr = data_sram_en &  is_mmio &  wr_any;
    assign mmio_rd = data_sram_en &  is_mmio & ~wr_any;

    always_ff @(posedge clk) begin
        if (mem_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (data_sram_we[b]) begin
                    mem_q[mem_idx][8*b +: 8] <= data_sram_wdata[8*b +: 8];
                end
            end
        end
        if (mem_rd) begin
            mem_rdata_q <= mem_q[mem_idx];
        end
    end

    assign fifo_push = mmio_wr & (off == OFF_CON_TX);

    resp_tx_fifo u_tx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (data_sram_wdata[7:0]),
        .pop       (con_ready),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .head      (fifo_head)
    );

    always_comb begin
        led_d   = led_q;
        cmp_d   = cmp_q;
        timer_d = timer_q + 32'd1;
        if (mmio_wr) begin
            case (off)
                OFF_LED:       led_d   = data_sram_wdata[15:0];
                OFF_TIMER:     timer_d = data_sram_wdata;
                OFF_TIMER_CMP: cmp_d   = data_sram_wdata;
                default: ;
            endcase
        end
        // A same-cycle match wins over a write-1-to-clear.
        pend_d = (timer_q == cmp_q) |
                 (pend_q & ~(mmio_wr & (off == OFF_INT_STAT) & data_sram_wdata[0]));
        ovf_d  = (ovf_q & ~(mmio_wr & (off == OFF_CON_STAT) & data_sram_wdata[CS_OVF_BIT])) |
                 (fifo_push & fifo_full & ~con_ready);
    end

    always_comb begin
        src_mem_d    = src_mem_q;
        mmio_rdata_d = mmio_rdata_q;
        if (mem_rd) begin
            src_mem_d = 1'b1;
        end else if (mmio_rd) begin
            src_mem_d = 1'b0;
            case (off)
                OFF_LED:       mmio_rdata_d = {16'h0000, led_q};
                OFF_TIMER:     mmio_rdata_d = timer_q;
                OFF_TIMER_CMP: mmio_rdata_d = cmp_q;
                OFF_INT_STAT:  mmio_rdata_d = {31'd0, pend_q};
                OFF_CON_STAT:  mmio_rdata_d = con_stat_word(fifo_full, fifo_empty, ovf_q, fifo_count);
                default:       mmio_rdata_d = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            src_mem_q    <= 1'b0;
            mmio_rdata_q <= 32'd0;
            led_q        <= 16'h0000;
            timer_q      <= 32'd0;
            cmp_q        <= 32'hFFFF_FFFF;
            pend_q       <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            src_mem_q    <= src_mem_d;
            mmio_rdata_q <= mmio_rdata_d;
            led_q        <= led_d;
            timer_q      <= timer_d;
            cmp_q        <= cmp_d;
            pend_q       <= pend_d;
            ovf_q        <= ovf_d;
        end
    end

    assign data_sram_rdata = src_mem_q ? mem_rdata_q : mmio_rdata_q;
    assign led             = led_q;
    assign timer_int       = pend_q;
    assign con_valid       = ~fifo_empty;
    assign con_data        = fifo_head;

endmodule
